uart_rx_core: RTL and testbench
===============================

# uart_rx_core

Serial receive front end of the UART: synchronises the asynchronous `rx_in` line, detects start bits, samples 8 data bits LSB-first at mid-bit using 16x oversampling, checks the stop bit, and presents each good byte to the receive FIFO. It sits directly upstream of the receive FIFO. `rx_valid` drives the FIFO's write-enable, which is rising-edge sensitive, and `data_out` drives its data input.

## Interface
- `OVERSAMPLE`, 16: sample ticks per bit; must be even and ≥ 4.
- `DIV_WIDTH`, 16: width of the baud divisor.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rx_in`  in  1  serial line, idle high, asynchronous to `clk`.
- `rx_en`  in  1  receiver enable; when low, the FSM is held in IDLE.
- `baud_div`  in  DIV_WIDTH  clocks per sample tick minus 1; sampled continuously, change only while `busy`=0.
- `parity_odd`  in  1  0 = even parity, 1 = odd parity; present only with `UART_RX_PARITY_EN`.
- `data_out`  out  8  last received byte; holds its value until the next good frame.
- `rx_valid`  out  1  single-cycle pulse for a good frame; this is the FIFO write strobe.
- `frame_err`  out  1  single-cycle pulse when the stop bit samples 0.
- `parity_err`  out  1  single-cycle pulse on parity mismatch; tied 0 without the macro.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- `rx_in` passes through a 2-flop synchroniser; all logic uses the synchronised `rxs`.
- Tick generator: counter runs 0..`baud_div` and emits `tick` on reaching `baud_div`, then wraps to 0. `baud_div`=0 produces a tick every clock. The counter is cleared on the start-edge detection cycle.
- Tick counter `tcnt` has width $clog2(OVERSAMPLE); bit counter `bcnt` is 3 bits.
- FSM states and transitions:
  - IDLE: wait for `rxs`=0 with `rx_en`=1 and the `armed` flag set, then go to START and clear the counters.
  - START: at tick OVERSAMPLE/2, sample the line. If `rxs`=1 (glitch), return to IDLE with no outputs. Otherwise go to DATA with `tcnt`=0.
  - DATA: on every OVERSAMPLE-th tick, shift `rxs` into bit[7] of the shift register (shift right). After 8 bits, go to PARITY if enabled, else STOP.
  - PARITY: sample one bit and compare it against XOR(data) XOR `parity_odd`. Latch the mismatch.
  - STOP: sample one bit, then return to IDLE. If the sample is 1 and there is no parity mismatch, load `data_out` and pulse `rx_valid`. If the sample is 0, pulse `frame_err`, suppress `rx_valid`, and clear `armed`. If the sample is 1 with a parity mismatch, pulse `parity_err` and suppress `rx_valid`.
- `armed` sets whenever `rxs`=1. This prevents a break condition (line held low) from re-triggering frames.
- The FSM returns to IDLE at mid-stop-bit, which allows resynchronisation to a back-to-back start bit.
- Dropping `rx_en` mid-frame aborts to IDLE on the next clock with no pulses. `data_out` is unchanged.

## Timing
- Reset values: `data_out`=0x00, `rx_valid`=`frame_err`=`parity_err`=`busy`=0, state IDLE, `armed`=0, synchroniser flops=1.
- Latency: the status pulse is asserted exactly 1 clk after the stop-bit sample tick. The stop-bit sample tick occurs (OVERSAMPLE/2 + 9·OVERSAMPLE)·(`baud_div`+1) clocks after the start-detect cycle, plus OVERSAMPLE·(`baud_div`+1) clocks with parity. The start-detect cycle is 2 clocks after `rx_in` falls.
- Pulses are exactly 1 clk wide. Consecutive frames are separated by at least one bit time, so the FIFO always sees a clean rising edge.
- `data_out` updates in the same cycle that `rx_valid` rises, and is stable for the whole frame time that follows.
- Reset asserted mid-frame returns all state to reset values immediately.

## Configuration
- `UART_RX_PARITY_EN` defined: the PARITY state, the `parity_odd` port and the mismatch check are compiled in, giving a frame of 11 bits.
- `UART_RX_PARITY_EN` undefined: the FSM skips directly from DATA to STOP, `parity_err` is tied 0, and the frame is 10 bits.

## Structure
- Shared package `uart_pkg`:
  - the `rx_state_t` enum (IDLE, START, DATA, PARITY, STOP);
  - the default OVERSAMPLE constant;
  - the frame-length localparams.
- Sub-module `uart_baud_gen`: the divisor counter plus tick output, with a synchronous clear input. It is reused by the transmitter.

## Test plan
- **Good byte:** `baud_div`=3; send 0xA5, 8N1, parity compiled out → exactly one `rx_valid` pulse, 1+2+608 clocks after `rx_in` falls; `data_out`=0xA5.
- **Back-to-back bytes:** send 0x00, then 0xFF with no idle gap → two `rx_valid` pulses; `data_out` reads 0x00 then 0xFF; no errors.
- **Glitch rejection:** `rx_in` low for 4 clocks with `baud_div`=3 → no pulses; `busy` returns to 0 at mid-start.
- **Framing error and break:** send 0x3C with stop bit = 0 → one `frame_err` pulse, no `rx_valid`, `data_out` unchanged. Then hold the line low for 40 bit times → no further pulses until the line returns high.
- **Parity (macro defined, `parity_odd`=0):** send 0x07 with parity bit 1 → `rx_valid`, `data_out`=0x07. Send 0x07 with parity bit 0 → `parity_err` only.
- **Mid-frame abort:** assert `rst_n`=0 mid-frame → all outputs read 0 on the next clock. Drop `rx_en` mid-frame → return to IDLE with no pulses.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and frame constants
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int OVERSAMPLE_DEF   = 16;
  localparam int FRAME_BITS_NOPAR = 10;
  localparam int FRAME_BITS_PAR   = 11;

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - divisor counter emitting one tick every i_div+1 clocks
module uart_baud_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_clr,
  input  logic [DIV_WIDTH-1:0] i_div,
  output logic                 o_tick
);

  logic [DIV_WIDTH-1:0] r_cnt;
  logic                 w_hit;

  assign w_hit  = (r_cnt == i_div);
  assign o_tick = w_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || w_hit) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 16x oversampled UART receiver, 8 data bits LSB first.
// Optional parity bit compiled in with UART_RX_PARITY_EN.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_in,
  input  logic                 rx_en,
  input  logic [DIV_WIDTH-1:0] baud_div,
`ifdef UART_RX_PARITY_EN
  input  logic                 parity_odd,
`endif
  output logic [7:0]           data_out,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_T = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST_T = TW'(OVERSAMPLE - 1);

  rx_state_t r_state, w_state_nxt;
  logic          r_sync1, r_sync2;
  logic [TW-1:0] r_tcnt;
  logic [2:0]    r_bcnt;
  logic [7:0]    r_shift, r_data;
  logic          r_par_err, r_armed;
  logic          r_valid, r_ferr, r_perr;
  logic          w_rxs, w_tick, w_start, w_mid, w_bit_end;
  logic          w_ok, w_ferr, w_perr;
`ifdef UART_RX_PARITY_EN
  logic          w_par_bad;
  assign w_par_bad = w_rxs != (^r_shift ^ parity_odd);
`endif

  assign w_rxs     = r_sync2;
  assign w_mid     = w_tick && (r_tcnt == HALF_T);
  assign w_bit_end = w_tick && (r_tcnt == LAST_T);

  uart_baud_gen #(.DIV_WIDTH(DIV_WIDTH)) u_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_start),
    .i_div  (baud_div),
    .o_tick (w_tick)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_ok        = 1'b0;
    w_ferr      = 1'b0;
    w_perr      = 1'b0;
    case (r_state)
      IDLE: if (r_armed && !w_rxs) begin
        w_start     = 1'b1;
        w_state_nxt = START;
      end
      START: if (w_mid) w_state_nxt = w_rxs ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
      DATA:   if (w_bit_end && r_bcnt == 3'd7) w_state_nxt = PARITY;
      PARITY: if (w_bit_end) w_state_nxt = STOP;
`else
      DATA:   if (w_bit_end && r_bcnt == 3'd7) w_state_nxt = STOP;
`endif
      STOP: if (w_bit_end) begin
        // Leave at mid-stop so a back-to-back start edge is caught.
        w_state_nxt = IDLE;
        if (!w_rxs)         w_ferr = 1'b1;
        else if (r_par_err) w_perr = 1'b1;
        else                w_ok   = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (!rx_en) begin
      w_state_nxt = IDLE;
      w_start     = 1'b0;
      w_ok        = 1'b0;
      w_ferr      = 1'b0;
      w_perr      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_tcnt    <= '0;
      r_bcnt    <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_par_err <= 1'b0;
      r_armed   <= 1'b0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_perr    <= 1'b0;
    end else begin
      r_sync1 <= rx_in;
      r_sync2 <= r_sync1;
      r_state <= w_state_nxt;
      r_valid <= w_ok;
      r_ferr  <= w_ferr;
      r_perr  <= w_perr;
      // A break leaves the line low; stay disarmed until it idles high again.
      if (w_rxs)       r_armed <= 1'b1;
      else if (w_ferr) r_armed <= 1'b0;
      if (w_ok) r_data <= r_shift;
      if (w_start) begin
        r_tcnt    <= '0;
        r_bcnt    <= '0;
        r_par_err <= 1'b0;
      end else if (w_tick && r_state != IDLE) begin
        if ((r_state == START && w_mid) || w_bit_end) r_tcnt <= '0;
        else                                          r_tcnt <= r_tcnt + TW'(1);
        if (r_state == DATA && w_bit_end) begin
          r_shift <= {w_rxs, r_shift[7:1]};
          r_bcnt  <= r_bcnt + 3'd1;
        end
`ifdef UART_RX_PARITY_EN
        if (r_state == PARITY && w_bit_end) r_par_err <= w_par_bad;
`endif
      end
    end
  end

  assign data_out   = r_data;
  assign rx_valid   = r_valid;
  assign frame_err  = r_ferr;
  assign parity_err = r_perr;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - scoreboard bench for uart_rx_core; honours UART_RX_PARITY_EN
module tb_uart_rx_core;

  localparam int OS = 16;
  localparam int BD = 3;
  localparam int BT = OS * (BD + 1);
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam longint LAT = 3 + longint'((OS / 2 + 9 * OS + PB * OS) * (BD + 1));

  localparam logic [2:0] K_VALID = 3'b001;
  localparam logic [2:0] K_FERR  = 3'b010;
  localparam logic [2:0] K_PERR  = 3'b100;

  typedef struct {
    logic [2:0] kind;
    logic [7:0] data;
    longint     cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_in = 1'b1;
  logic        rx_en = 1'b0;
  logic [15:0] baud_div = 16'(BD);
  logic        parity_odd = 1'b0;
  logic [7:0]  data_out;
  logic        rx_valid, frame_err, parity_err, busy;

  int     n_vec = 0;
  int     n_err = 0;
  longint cyc = 0;
  exp_t   exp_q[$];

  uart_rx_core #(.OVERSAMPLE(OS), .DIV_WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_in      (rx_in),
    .rx_en      (rx_en),
    .baud_div   (baud_div),
`ifdef UART_RX_PARITY_EN
    .parity_odd (parity_odd),
`endif
    .data_out   (data_out),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] k, input logic [7:0] d, input longint c);
    exp_t e;
    e.kind = k;
    e.data = d;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic run_monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (rx_valid || frame_err || parity_err)) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_pulse: got flags=%b data=0x%02h cycle=%0d, required no pulse",
                   {parity_err, frame_err, rx_valid}, data_out, cyc);
        end else begin
          e = exp_q.pop_front();
          if ({parity_err, frame_err, rx_valid} !== e.kind || data_out !== e.data ||
              (e.cyc >= 0 && cyc != e.cyc)) begin
            n_err++;
            $display("FAIL pulse: got flags=%b data=0x%02h cycle=%0d, required flags=%b data=0x%02h cycle=%0d",
                     {parity_err, frame_err, rx_valid}, data_out, cyc, e.kind, e.data, e.cyc);
          end
        end
      end
    end
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx_in = b;
    repeat (BT) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^d ^ parity_odd);
`endif
    send_bit(stop);
  endtask

  task automatic wait_cyc(input longint target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    longint c0;
    fork
      run_monitor();
    join_none

    repeat (3) @(negedge clk);
    check("reset_outputs", {23'd0, data_out, rx_valid, frame_err, parity_err, busy}, 32'd0);
    align();
    rst_n = 1'b1;
    rx_en = 1'b1;
    repeat (8) align();

    // good byte with exact latency
    push(K_VALID, 8'hA5, cyc + LAT);
    send_frame(8'hA5, 1'b1);
    send_bit(1'b1);

    // back-to-back bytes, no idle gap
    push(K_VALID, 8'h00, -1);
    push(K_VALID, 8'hFF, -1);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_bit(1'b1);

    // glitch: 4 clocks low
    c0 = cyc;
    rx_in = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx_in = 1'b1;
    wait_cyc(c0 + 20);
    check("glitch_busy_start", {31'd0, busy}, 32'd1);
    wait_cyc(c0 + 36);
    check("glitch_busy_idle", {31'd0, busy}, 32'd0);
    align();
    send_bit(1'b1);

    // framing error followed by a 40-bit break
    push(K_FERR, 8'hFF, -1);
    send_frame(8'h3C, 1'b0);
    repeat (40) send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    check("break_busy", {31'd0, busy}, 32'd0);
    check("break_data_hold", {24'd0, data_out}, 32'hFF);

    push(K_VALID, 8'h5A, -1);
    send_frame(8'h5A, 1'b1);
    send_bit(1'b1);

`ifdef UART_RX_PARITY_EN
    parity_odd = 1'b0;
    push(K_VALID, 8'h07, -1);
    send_frame(8'h07, 1'b1);
    send_bit(1'b1);
    push(K_PERR, 8'h07, -1);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(i < 3);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
`endif

    // reset mid-frame
    send_bit(1'b0);
    send_bit(1'b1);
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    rx_in = 1'b1;
    @(negedge clk);
    check("midframe_reset", {23'd0, data_out, rx_valid, frame_err, parity_err, busy}, 32'd0);
    align();
    rst_n = 1'b1;
    repeat (8) align();

    // rx_en drop mid-frame
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    check("pre_abort_busy", {31'd0, busy}, 32'd1);
    rx_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    align();
    rx_in = 1'b1;
    send_bit(1'b1);
    send_bit(1'b1);
    check("abort_data_hold", {24'd0, data_out}, 32'h00);
    rx_en = 1'b1;
    send_bit(1'b1);

    push(K_VALID, 8'hC3, -1);
    send_frame(8'hC3, 1'b1);
    send_bit(1'b1);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
